// File: rtl/logic_unit_arbiter_pkg.sv
// Shared opcode and FSM state encodings for the round-robin logic-unit arbiter.
package logic_unit_arbiter_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

endpackage

// File: rtl/logic_unit.sv
// Combinational bitwise logic unit: AND/OR/XOR/NAND over WIDTH bits.
module logic_unit
  import logic_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] and_y;
  logic [WIDTH-1:0] or_y;
  logic [WIDTH-1:0] xor_y;
  logic [WIDTH-1:0] nand_y;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    and  u_and  (and_y[i],  a[i], b[i]);
    or   u_or   (or_y[i],   a[i], b[i]);
    xor  u_xor  (xor_y[i],  a[i], b[i]);
    nand u_nand (nand_y[i], a[i], b[i]);
  end

  always_comb begin
    y = and_y;
    unique case (op)
      OP_AND:  y = and_y;
      OP_OR:   y = or_y;
      OP_XOR:  y = xor_y;
      OP_NAND: y = nand_y;
      default: y = and_y;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered logic unit between N_REQ requesters,
// sequencing each operation through grant, execute and respond.
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int PTR_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     op_i,
  input  logic [WIDTH*N_REQ-1:0] a_i,
  input  logic [WIDTH*N_REQ-1:0] b_i,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       res,
  output logic                   busy
);

  logic [1:0]       state_q;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] win_q;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] done_q;
  logic [WIDTH-1:0] res_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] lu_y;

  logic [PTR_W:0]   pick;
  logic             pick_valid;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] ptr_next;

  // Returns {found, index} of the first set request scanning from p upwards, modulo N_REQ.
  function automatic logic [PTR_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [PTR_W-1:0] p);
    logic [PTR_W:0] sel;
    int             idx;
    sel = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(p) + i) % N_REQ;
      if (r[idx]) sel = {1'b1, PTR_W'(idx)};
    end
    return sel;
  endfunction

  assign pick       = rr_pick(req, ptr_q);
  assign pick_valid = pick[PTR_W];
  assign pick_idx   = pick[PTR_W-1:0];
  assign ptr_next   = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;

  logic_unit #(
    .WIDTH(WIDTH)
  ) u_logic_unit (
    .op(op_q),
    .a (a_q),
    .b (b_q),
    .y (lu_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      res_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_valid) begin
            op_q    <= op_i[2*int'(pick_idx) +: 2];
            a_q     <= a_i[WIDTH*int'(pick_idx) +: WIDTH];
            b_q     <= b_i[WIDTH*int'(pick_idx) +: WIDTH];
            win_q   <= pick_idx;
            gnt_q   <= N_REQ'(1) << pick_idx;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_q   <= lu_y;
          done_q  <= gnt_q;
          state_q <= S_RESP;
        end
        S_RESP: begin
          done_q  <= '0;
          gnt_q   <= '0;
          ptr_q   <= ptr_next;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign res  = res_q;
  assign busy = (state_q != S_IDLE);

endmodule
